// File: rtl/cpu_control_unit.sv
// Moore control sequencer for the simple-CPU datapath: fetch in T0-T2, then
// decode/execute of three-register ALU instructions in T3-T5.
//
// state | meaning
// ------+-----------------------------------------------------------
// RST   | held in reset, all strobes low, run low
// T0    | PC onto bus, load MAR, increment PC into Z
// T1    | Z back into PC, memory read into MDR; waits for mem_ready
// T2    | MDR onto bus, load IR
// T3    | decode: ALU ops load rb into Y; nop/illegal retire; halt stops
// T4    | rc onto bus, ALU result into Z
// T5    | Z low onto bus, write ra; instruction retires
// HALT  | stopped until Reset, run low
module cpu_control_unit #(
    parameter int OPW  = 5,
    parameter int CNTW = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    output logic            PCout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            MARin,
    output logic            Zin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            IncPC,
    output logic            Read,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic [OPW-1:0]  alu_op,
    output logic            run,
    output logic            illegal,
    output logic [CNTW-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_ALU_LO = OPW'(3);
    localparam logic [OPW-1:0] OP_ALU_HI = OPW'(11);
    localparam logic [OPW-1:0] OP_NOP    = OPW'(26);
    localparam logic [OPW-1:0] OP_HALT   = OPW'(27);

    state_t state;
    state_t state_next;

    logic [OPW-1:0] opcode;
    logic           op_is_alu;
    logic           op_is_nop;
    logic           op_is_halt;
    logic           retire;

    // Register fields are decoded downstream; only the opcode matters here.
    logic ir_unused;
    assign ir_unused = ^ir[31-OPW:0];

    assign opcode     = ir[31 -: OPW];
    assign op_is_alu  = (opcode >= OP_ALU_LO) && (opcode <= OP_ALU_HI);
    assign op_is_nop  = (opcode == OP_NOP);
    assign op_is_halt = (opcode == OP_HALT);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_RST;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNTW'(1);
        end
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        PCout      = 1'b0;
        Zlowout    = 1'b0;
        MDRout     = 1'b0;
        MARin      = 1'b0;
        Zin        = 1'b0;
        PCin       = 1'b0;
        MDRin      = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        IncPC      = 1'b0;
        Read       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        alu_op     = '0;
        run        = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_RST: begin
                state_next = S_T0;
            end
            S_T0: begin
                run        = 1'b1;
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zin        = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                // Reloading PC from Z while waiting is harmless: Z is frozen.
                run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) begin
                    state_next = S_T2;
                end
            end
            S_T2: begin
                run        = 1'b1;
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                run = 1'b1;
                if (op_is_alu) begin
                    Grb        = 1'b1;
                    Rout       = 1'b1;
                    Yin        = 1'b1;
                    state_next = S_T4;
                end else if (op_is_halt) begin
                    state_next = S_HALT;
                end else begin
                    illegal    = !op_is_nop;
                    retire     = 1'b1;
                    state_next = S_T0;
                end
            end
            S_T4: begin
                run        = 1'b1;
                Grc        = 1'b1;
                Rout       = 1'b1;
                Zin        = 1'b1;
                alu_op     = opcode;
                state_next = S_T5;
            end
            S_T5: begin
                run        = 1'b1;
                Zlowout    = 1'b1;
                Gra        = 1'b1;
                Rin        = 1'b1;
                retire     = 1'b1;
                state_next = S_T0;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_RST;
            end
        endcase
    end

endmodule
